// File: rtl/rv32i_mem_arbiter_if.sv
// rtl/rv32i_mem_arbiter_if.sv - core-side and memory-side bus bundle for the rv32i memory arbiter
interface rv32i_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // instruction-fetch port
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;

   // load/store port
   logic              d_req;
   logic              d_we;
   logic [BE_W-1:0]   d_be;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              err;

   // shared memory bus
   logic              m_req;
   logic              m_we;
   logic [BE_W-1:0]   m_be;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_ack;
   logic [DATA_W-1:0] m_rdata;

   logic              stall;

   // arbiter view
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err,
      output m_req, m_we, m_be, m_addr, m_wdata, stall
   );

   // core + memory environment view
   modport master (
      output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err,
      input  m_req, m_we, m_be, m_addr, m_wdata, stall
   );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// rtl/rv32i_mem_arbiter.sv - round-robin fetch/load-store arbiter onto one memory bus with timeout
module rv32i_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rstn,
   rv32i_mem_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;
   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t            state;
   state_t            state_next;
   logic              last_d;      // 1 when the most recent grant went to the data port
   logic [7:0]        cnt;
   logic              elig_i;
   logic              elig_d;
   logic              gnt_i;
   logic              gnt_d;
   logic              done;
   logic              tout;

   logic              m_req_q;
   logic              m_we_q;
   logic [BE_W-1:0]   m_be_q;
   logic [ADDR_W-1:0] m_addr_q;
   logic [DATA_W-1:0] m_wdata_q;
   logic              i_rvalid_q;
   logic              d_rvalid_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              err_q;

   // Grant arbitration, completion/timeout detection and next state.
   // A port finishing this cycle is not re-granted in the same cycle.
   always_comb begin
      elig_i     = 1'b0;
      elig_d     = 1'b0;
      gnt_i      = 1'b0;
      gnt_d      = 1'b0;
      done       = 1'b0;
      tout       = 1'b0;
      state_next = state;
      if (rstn) begin
         case (state)
            IDLE: begin
               elig_i = bus.i_req & ~i_rvalid_q;
               elig_d = bus.d_req & ~d_rvalid_q;
               gnt_i  = elig_i & (~elig_d | last_d);
               gnt_d  = elig_d & (~elig_i | ~last_d);
               if (gnt_i)      state_next = BUSY_I;
               else if (gnt_d) state_next = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
               if (bus.m_ack)           done = 1'b1;
               else if (cnt == CNT_MAX) tout = 1'b1;
               if (done || tout) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   // Memory-bus launch, watchdog counter and completion pulses.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_d     <= 1'b0;
         cnt        <= '0;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_be_q     <= '0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         err_q      <= 1'b0;
         if (gnt_i) begin
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_be_q    <= '1;
            m_addr_q  <= bus.i_addr;
            m_wdata_q <= '0;
            last_d    <= 1'b0;
            cnt       <= '0;
         end else if (gnt_d) begin
            m_req_q   <= 1'b1;
            m_we_q    <= bus.d_we;
            m_be_q    <= bus.d_be;
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
            last_d    <= 1'b1;
            cnt       <= '0;
         end else if (done || tout) begin
            m_req_q <= 1'b0;
            cnt     <= '0;
            err_q   <= tout;
            if (state == BUSY_I) begin
               i_rvalid_q <= 1'b1;
               i_rdata_q  <= tout ? '0 : bus.m_rdata;
            end else begin
               d_rvalid_q <= 1'b1;
               d_rdata_q  <= (tout || m_we_q) ? '0 : bus.m_rdata;
            end
         end else if (state != IDLE) begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   assign bus.i_gnt    = gnt_i;
   assign bus.d_gnt    = gnt_d;
   assign bus.i_rvalid = i_rvalid_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.i_rdata  = i_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.err      = err_q;
   assign bus.m_req    = m_req_q;
   assign bus.m_we     = m_we_q;
   assign bus.m_be     = m_be_q;
   assign bus.m_addr   = m_addr_q;
   assign bus.m_wdata  = m_wdata_q;
   assign bus.stall    = ~rstn | (state != IDLE) | (bus.i_req & ~gnt_i) | (bus.d_req & ~gnt_d);
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb/tb_rv32i_mem_arbiter.sv - self-checking bench for the rv32i memory arbiter
module tb_rv32i_mem_arbiter;
   localparam int TIMEOUT = 64;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   rv32i_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   typedef struct {
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mem;
      int          lat;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];

   int pass_cnt = 0;
   int total    = 0;

   // memory responder: acks in the ack_lat-th cycle of m_req (0 = never)
   int          ack_lat    = 0;
   int          req_cycles = 0;
   logic        resp_ack   = 1'b0;
   logic        man_ack    = 1'b0;
   logic [31:0] mem_rdata  = 32'h0;

   assign bus.m_ack   = resp_ack | man_ack;
   assign bus.m_rdata = mem_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      total++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         resp_ack = 1'b0;
         if (!bus.m_req) req_cycles = 0;
         else begin
            req_cycles++;
            if (ack_lat != 0 && req_cycles == ack_lat) resp_ack = 1'b1;
         end
      end
   end

   // scoreboard: every completion pulse pops and checks the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (bus.i_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
         if (sb.size() == 0) fail_now("unexpected_rvalid");
         else begin
            e = sb.pop_front();
            chk("rv_both", {31'd0, bus.i_rvalid & bus.d_rvalid}, 32'd0);
            chk("rv_port", {31'd0, bus.d_rvalid}, {31'd0, e.is_d});
            chk("rv_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
            chk("rv_err", {31'd0, bus.err}, {31'd0, e.err});
         end
      end else if (bus.err === 1'b1) begin
         fail_now("err_without_rvalid");
      end
   end

   task automatic wait_rv(input string tag);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (bus.i_rvalid || bus.d_rvalid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail_now(tag);
   endtask

   task automatic do_xfer(input vec_t v, input string tag);
      int   reqc;
      bit   got;
      exp_t e;
      tick();
      ack_lat   = v.lat;
      mem_rdata = v.mem;
      if (v.is_d) begin
         bus.d_req   = 1'b1;
         bus.d_we    = v.we;
         bus.d_be    = v.be;
         bus.d_addr  = v.addr;
         bus.d_wdata = v.wdata;
      end else begin
         bus.i_req  = 1'b1;
         bus.i_addr = v.addr;
      end
      e.is_d = v.is_d; e.rdata = v.exp_rdata; e.err = v.exp_err;
      sb.push_back(e);
      @(negedge clk);
      chk($sformatf("%s_gnt", tag), {30'd0, bus.d_gnt, bus.i_gnt}, v.is_d ? 32'd2 : 32'd1);
      tick();
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      @(negedge clk);
      chk($sformatf("%s_m_req", tag), {31'd0, bus.m_req}, 32'd1);
      chk($sformatf("%s_m_we", tag), {31'd0, bus.m_we}, v.is_d ? {31'd0, v.we} : 32'd0);
      chk($sformatf("%s_m_be", tag), {28'd0, bus.m_be}, v.is_d ? {28'd0, v.be} : 32'hF);
      chk($sformatf("%s_m_addr", tag), bus.m_addr, v.addr);
      if (v.is_d) chk($sformatf("%s_m_wdata", tag), bus.m_wdata, v.wdata);
      chk($sformatf("%s_stall_busy", tag), {31'd0, bus.stall}, 32'd1);
      reqc = 1;
      got  = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (bus.i_rvalid || bus.d_rvalid) begin
            got = 1'b1;
            break;
         end
         if (bus.m_req) reqc++;
      end
      if (!got) fail_now($sformatf("%s_no_rvalid", tag));
      else begin
         chk($sformatf("%s_req_cycles", tag), reqc, (v.lat == 0) ? TIMEOUT : v.lat);
         chk($sformatf("%s_stall_done", tag), {31'd0, bus.stall}, 32'd0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation bound expired");
      $fatal(1);
   end

   initial begin
      logic [1:0] cpat [8];
      exp_t       e;
      int         reqc;
      bit         got;

      //           is_d  we    be     addr          wdata         mem           lat exp_rdata     err
      vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,        32'h0050_0093, 3,  32'h0050_0093, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_2000, 32'hDEAD_BEEF, 32'h1234_5678, 1,  32'h0,         1'b0};
      vecs[2] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,        32'h0000_0013, 1,  32'h0000_0013, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h0000_3004, 32'h0,        32'hCAFE_F00D, 2,  32'hCAFE_F00D, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 4'hC, 32'h0000_0010, 32'h0BAD_F00D, 32'hFFFF_FFFF, 5,  32'h0,         1'b0};
      vecs[5] = '{1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0,        32'h1357_9BDF, 64, 32'h1357_9BDF, 1'b0};

      // reset with both requesters already waiting
      bus.i_req = 1'b1; bus.i_addr = 32'h40;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h80; bus.d_wdata = 32'h0;
      ack_lat = 1; mem_rdata = 32'h0000_BEEF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall}, 32'd1);
      chk("rst_m_req", {31'd0, bus.m_req}, 32'd0);
      chk("rst_pulses", {29'd0, bus.i_rvalid, bus.d_rvalid, bus.err}, 32'd0);
      chk("rst_m_addr", bus.m_addr, 32'd0);
      chk("rst_m_be", {28'd0, bus.m_be}, 32'd0);

      // contention out of reset: D,I,D,I every 2 cycles
      cpat = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
      for (int k = 0; k < 4; k++) begin
         e.is_d = (k % 2 == 0); e.rdata = 32'h0000_BEEF; e.err = 1'b0;
         sb.push_back(e);
      end
      tick();
      rstn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("contend_c%0d", k), {30'd0, bus.d_gnt, bus.i_gnt}, {30'd0, cpat[k]});
         if (k == 6) begin
            tick();
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
         end
      end
      wait_rv("contend_last_rvalid");

      // table-driven single transfers
      for (int i = 0; i < 6; i++) do_xfer(vecs[i], $sformatf("vec%0d", i));

      // timeout on a load, with a fetch queued behind it
      tick();
      ack_lat = 0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h4000;
      e.is_d = 1'b1; e.rdata = 32'h0; e.err = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      chk("to_gnt", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd2);
      tick();
      bus.d_req = 1'b0;
      bus.i_req = 1'b1; bus.i_addr = 32'h200;
      mem_rdata = 32'h00A0_0113;
      reqc = 0;
      got  = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (bus.i_rvalid || bus.d_rvalid) begin
            got = 1'b1;
            break;
         end
         if (bus.m_req) reqc++;
      end
      if (!got) fail_now("to_no_rvalid");
      chk("to_req_cycles", reqc, TIMEOUT);
      chk("to_next_gnt", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd1);
      e.is_d = 1'b0; e.rdata = 32'h00A0_0113; e.err = 1'b0;
      sb.push_back(e);
      ack_lat = 1;
      tick();
      bus.i_req = 1'b0;
      wait_rv("to_fetch_rvalid");

      // reset in the middle of a fetch, late ack, then a tie
      tick();
      ack_lat = 0;
      bus.i_req = 1'b1; bus.i_addr = 32'h300;
      @(negedge clk);
      chk("rm_gnt", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd1);
      tick();
      bus.i_req = 1'b0;
      tick();
      rstn = 1'b0;
      bus.i_req = 1'b1;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h500;
      @(negedge clk);
      chk("rm_gnt_in_rst", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd0);
      chk("rm_stall_in_rst", {31'd0, bus.stall}, 32'd1);
      tick();
      man_ack = 1'b1;
      @(negedge clk);
      chk("rm_m_req_dropped", {31'd0, bus.m_req}, 32'd0);
      chk("rm_stall_rst2", {31'd0, bus.stall}, 32'd1);
      chk("rm_no_rvalid", {30'd0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
      tick();
      man_ack = 1'b0;
      rstn = 1'b1;
      ack_lat = 1;
      mem_rdata = 32'h1111_2222;
      e.is_d = 1'b1; e.rdata = 32'h1111_2222; e.err = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      chk("rm_no_rvalid_after", {30'd0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
      chk("rm_tie_gnt_d", {30'd0, bus.d_gnt, bus.i_gnt}, 32'd2);
      tick();
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      wait_rv("rm_tie_rvalid");

      // spurious ack while idle
      tick();
      man_ack = 1'b1;
      @(negedge clk);
      chk("sp_stall_during", {31'd0, bus.stall}, 32'd0);
      tick();
      man_ack = 1'b0;
      @(negedge clk);
      chk("sp_pulses", {29'd0, bus.i_rvalid, bus.d_rvalid, bus.err}, 32'd0);
      chk("sp_m_req", {31'd0, bus.m_req}, 32'd0);
      chk("sp_stall", {31'd0, bus.stall}, 32'd0);
      do_xfer(vecs[2], "sp_after");

      repeat (3) tick();
      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
